sdm_interp: RTL and testbench
=============================

// Module: sdm_interp
// PURPOSE
//  Upstream feeder for the 1-bit sigma-delta modulator. Accepts signed PCM
//  samples through a valid/ready handshake into a small FIFO, converts them to
//  offset binary, and linearly interpolates by 2^R in the clk_fast domain.
//  dout drives the modulator's W-bit unsigned din input on every clk_fast cycle.
// PARAMETERS
//  W      12  sample / output width, bits
//  R      6   interpolation ratio is 2^R clk_fast cycles per input sample
//  A      2   FIFO address width; depth = 2^A entries
// PORTS
//  clk_fast      in   1  modulator clock; all logic on its rising edge
//  rst_n         in   1  asynchronous active-low reset
//  en            in   1  1 = interpolator advances; 0 = freeze phase and output
//  s_valid       in   1  upstream sample valid
//  s_ready       out  1  FIFO can accept (= !full)
//  s_data        in   W  signed two's-complement sample
//  dout          out  W  unsigned offset-binary sample to the modulator
//  seg_start     out  1  one-cycle pulse when a new interpolation segment loads
//  underrun      out  1  sticky; set when a segment ends with the FIFO empty
//  clr_underrun  in   1  synchronous clear of underrun
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, dout = 2^(W-1) (midscale), seg_start=0,
//   underrun=0, phase=0, prev=curr=2^(W-1). s_ready=1 during/after reset.
//  Handshake: push when s_valid & s_ready; s_data is written as offset binary
//   (MSB inverted). s_ready is registered-full based; no push when full.
//   s_valid may stay high; no combinational path from s_valid to s_ready.
//  FIFO: count 0..2^A; pointers wrap mod 2^A; push and pop in the same cycle
//   leave count unchanged. Pop happens only at segment load (below).
//  States: IDLE -> RUN when en=1 and count>=1 (the load cycle). RUN is exited
//   only by reset. en=0 in RUN: phase, acc, dout held; FIFO still accepts.
//  Segment load (IDLE->RUN, or RUN with en=1 and phase=2^R-1):
//   - count>=1: prev<=curr; curr<=FIFO head; pop; seg_start=1 next cycle.
//   - count==0 (RUN only): prev<=curr; curr unchanged (delta=0, output holds);
//     underrun<=1; seg_start=1. A push in that same cycle is written, not
//     bypassed; it is consumed at the next segment load.
//   - phase<=0; acc<=curr_old<<R (i.e. the new prev, unsigned W+R bits).
//  Within a segment (RUN, en=1, not a load): phase<=phase+1; acc<=acc+delta,
//   delta = curr - prev as signed W+1 bits, acc signed W+R+1 bits.
//  Output: dout = acc[W+R-1:R] registered; at phase p dout =
//   prev + floor((curr-prev)*p / 2^R). Values stay within [prev,curr] so acc
//   never leaves [0, 2^(W+R)-1]; no saturation logic needed.
//  Latency: sample pushed at edge t -> load at edge t+1 (IDLE, en=1) -> dout
//   leaves midscale at t+2; dout equals that sample exactly at the start of
//   the following segment (2^R cycles after load).
//  underrun: set wins over clr_underrun in the same cycle.
//  Reset mid-operation: all state, FIFO contents and flags return to reset
//   values immediately; dout jumps to midscale.
// TESTING
//  1 Reset, en=1, no input -> state IDLE, dout=0x800, s_ready=1, no seg_start.
//  2 Push 0x7FF then 0x7FF (W=12,R=6) -> dout ramps 0x800..0xFFF by ~32/cycle
//    (+2047/64 per phase, floored), holds 0xFFF through second segment.
//  3 Push 0x800 (-2048) once then stop -> ramp to 0x000, next segment load
//    with empty FIFO sets underrun and dout holds 0x000; clr_underrun clears it.
//  4 Hold s_valid=1 with en=0 -> exactly 4 accepts, s_ready=0 after the 4th;
//    raise en -> one pop per 64 cycles, s_ready re-asserts the cycle after pop.
//  5 Drop en for 10 cycles mid-segment -> dout and phase frozen; segment
//    length measured in en=1 cycles remains 64.
//  6 Assert rst_n=0 mid-ramp with FIFO half full -> next sample dout=0x800,
//    FIFO empty, underrun=0, s_ready=1.

Source files
------------

// File: rtl/sdm_interp.sv
// PCM feeder for the 1-bit sigma-delta modulator: valid/ready FIFO, offset-binary
// conversion and linear interpolation by 2^R in the clk_fast domain.
module sdm_interp #(
    parameter int W = 12,
    parameter int R = 6,
    parameter int A = 2
) (
    input  logic         clk_fast,
    input  logic         rst_n,
    input  logic         en,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic [W-1:0] dout,
    output logic         seg_start,
    output logic         underrun,
    input  logic         clr_underrun
);

    localparam int DEPTH = 1 << A;
    localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [W-1:0]        mem [DEPTH];
    logic [A-1:0]        wr_ptr;
    logic [A-1:0]        rd_ptr;
    logic [A:0]          count;
    logic [A:0]          count_nxt;
    logic                full_r;
    logic [R-1:0]        phase;
    logic [W-1:0]        prev;
    logic [W-1:0]        curr;
    logic signed [W+R:0] acc;
    logic signed [W:0]   delta;
    logic                push;
    logic                pop;
    logic                load;
    logic                fifo_empty;

    function automatic logic [W-1:0] to_offset(input logic [W-1:0] x);
        return {~x[W-1], x[W-2:0]};
    endfunction

    function automatic logic signed [W+R:0] sext_delta(input logic signed [W:0] d);
        return {{R{d[W]}}, d};
    endfunction

    assign fifo_empty = (count == '0);
    assign s_ready    = ~full_r;
    assign push       = s_valid & ~full_r;
    assign load       = en && (((state == IDLE) && !fifo_empty) ||
                               ((state == RUN) && (phase == {R{1'b1}})));
    assign pop        = load & ~fifo_empty;
    assign count_nxt  = count + (A+1)'(push) - (A+1)'(pop);
    assign delta      = $signed({1'b0, curr}) - $signed({1'b0, prev});
    assign dout       = acc[W+R-1:R];

    // FIFO: full flag is registered so s_ready never depends on s_valid
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_r <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= to_offset(s_data);
                wr_ptr      <= wr_ptr + A'(1);
            end
            if (pop) rd_ptr <= rd_ptr + A'(1);
            count  <= count_nxt;
            full_r <= (count_nxt == (A+1)'(DEPTH));
        end
    end

    // Interpolator: acc holds prev<<R plus p*delta, so its upper bits are the output
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= '0;
            prev      <= MID;
            curr      <= MID;
            acc       <= $signed({1'b0, MID, {R{1'b0}}});
            seg_start <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            seg_start <= load;
            if (load) begin
                state <= RUN;
                prev  <= curr;
                if (!fifo_empty) curr <= mem[rd_ptr];
                phase <= '0;
                acc   <= $signed({1'b0, curr, {R{1'b0}}});
            end else if ((state == RUN) && en) begin
                phase <= phase + R'(1);
                acc   <= acc + sext_delta(delta);
            end
            if (load && fifo_empty) underrun <= 1'b1;
            else if (clr_underrun)  underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdm_interp.sv
// Directed bench for sdm_interp (W=12, R=6, A=2): vector tables for the ramps,
// hand sequences for backpressure, en freeze and asynchronous reset.
module tb_sdm_interp;

    logic        clk_fast = 1'b0;
    logic        rst_n;
    logic        en;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_data;
    logic [11:0] dout;
    logic        seg_start;
    logic        underrun;
    logic        clr_underrun;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          ncyc;
        logic [11:0] exp_dout;
        logic        exp_seg;
        logic        exp_unr;
    } vec_t;

    vec_t up_tab[8];
    vec_t dn_tab[6];

    sdm_interp #(.W(12), .R(6), .A(2)) dut (
        .clk_fast     (clk_fast),
        .rst_n        (rst_n),
        .en           (en),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .dout         (dout),
        .seg_start    (seg_start),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic step();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        en           = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        clr_underrun = 1'b0;
        rst_n        = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_vec(input string tag, input int idx, input vec_t v);
        repeat (v.ncyc) step();
        chk($sformatf("%s[%0d].dout", tag, idx), int'(dout), int'(v.exp_dout));
        chk($sformatf("%s[%0d].seg_start", tag, idx), int'(seg_start), int'(v.exp_seg));
        chk($sformatf("%s[%0d].underrun", tag, idx), int'(underrun), int'(v.exp_unr));
    endtask

    // Steps until seg_start is seen; n = number of steps, or -1 on timeout
    task automatic wait_seg(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (seg_start) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int accepts;
        logic rdy;

        // +2047/64 per phase from midscale, then flat at full scale
        up_tab[0] = '{1,  12'h81F, 1'b0, 1'b0};
        up_tab[1] = '{1,  12'h83F, 1'b0, 1'b0};
        up_tab[2] = '{30, 12'hBFF, 1'b0, 1'b0};
        up_tab[3] = '{31, 12'hFDF, 1'b0, 1'b0};
        up_tab[4] = '{1,  12'hFFF, 1'b1, 1'b0};
        up_tab[5] = '{1,  12'hFFF, 1'b0, 1'b0};
        up_tab[6] = '{62, 12'hFFF, 1'b0, 1'b0};
        up_tab[7] = '{1,  12'hFFF, 1'b1, 1'b1};
        // -32 per phase from midscale down to zero, then underrun hold
        dn_tab[0] = '{1,  12'h800, 1'b1, 1'b0};
        dn_tab[1] = '{1,  12'h7E0, 1'b0, 1'b0};
        dn_tab[2] = '{31, 12'h400, 1'b0, 1'b0};
        dn_tab[3] = '{31, 12'h020, 1'b0, 1'b0};
        dn_tab[4] = '{1,  12'h000, 1'b1, 1'b1};
        dn_tab[5] = '{10, 12'h000, 1'b0, 1'b1};

        // Idle after reset
        do_reset();
        en = 1'b1;
        repeat (5) step();
        chk("idle.dout", int'(dout), 'h800);
        chk("idle.s_ready", int'(s_ready), 1);
        chk("idle.seg_start", int'(seg_start), 0);
        chk("idle.underrun", int'(underrun), 0);

        // Two full-scale positive samples
        do_reset();
        en      = 1'b1;
        s_valid = 1'b1;
        s_data  = 12'h7FF;
        step();
        chk("up.push.dout", int'(dout), 'h800);
        chk("up.push.seg_start", int'(seg_start), 0);
        step();
        s_valid = 1'b0;
        chk("up.load.dout", int'(dout), 'h800);
        chk("up.load.seg_start", int'(seg_start), 1);
        foreach (up_tab[i]) run_vec("up", i, up_tab[i]);

        // Single full-scale negative sample, underrun, clear and set-wins
        do_reset();
        en      = 1'b1;
        s_valid = 1'b1;
        s_data  = 12'h800;
        step();
        s_valid = 1'b0;
        chk("dn.push.dout", int'(dout), 'h800);
        foreach (dn_tab[i]) run_vec("dn", i, dn_tab[i]);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        chk("dn.clr.underrun", int'(underrun), 0);
        repeat (52) step();
        chk("dn.pre_load.seg_start", int'(seg_start), 0);
        clr_underrun = 1'b1;
        step();
        chk("dn.setwins.seg_start", int'(seg_start), 1);
        chk("dn.setwins.underrun", int'(underrun), 1);
        chk("dn.setwins.dout", int'(dout), 'h000);
        step();
        clr_underrun = 1'b0;
        chk("dn.clr2.underrun", int'(underrun), 0);

        // Backpressure: en=0, s_valid held high
        do_reset();
        s_valid = 1'b1;
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            s_data = 12'((accepts + 1) * 256);
            rdy    = s_ready;
            step();
            if (rdy) accepts++;
        end
        chk("bp.accepts", accepts, 4);
        chk("bp.s_ready_full", int'(s_ready), 0);
        chk("bp.idle_dout", int'(dout), 'h800);
        en = 1'b1;
        step();
        chk("bp.load1.seg_start", int'(seg_start), 1);
        chk("bp.after_pop.s_ready", int'(s_ready), 1);
        step();
        s_valid = 1'b0;
        chk("bp.refill.s_ready", int'(s_ready), 0);
        wait_seg(200, n);
        chk("bp.seg_period", (n < 0) ? -1 : n + 1, 64);
        chk("bp.load2.dout", int'(dout), 'h900);
        chk("bp.load2.s_ready", int'(s_ready), 1);

        // en freeze mid-segment (prev=0x900, curr=0xA00, +4 per phase)
        repeat (20) step();
        chk("frz.p20.dout", int'(dout), 'h950);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("frz.hold%0d.seg_start", i), int'(seg_start), 0);
        end
        chk("frz.held.dout", int'(dout), 'h950);
        en = 1'b1;
        wait_seg(200, n);
        chk("frz.en_cycles", (n < 0) ? -1 : 20 + n, 64);
        chk("frz.load.dout", int'(dout), 'hA00);
        chk("frz.underrun", int'(underrun), 0);

        // Asynchronous reset mid-ramp with FIFO partly full
        repeat (10) step();
        chk("rst.pre.s_ready", int'(s_ready), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.async.dout", int'(dout), 'h800);
        chk("rst.async.s_ready", int'(s_ready), 1);
        chk("rst.async.underrun", int'(underrun), 0);
        chk("rst.async.seg_start", int'(seg_start), 0);
        step();
        rst_n = 1'b1;
        en    = 1'b1;
        n     = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (seg_start) n++;
        end
        chk("rst.empty.seg_starts", n, 0);
        chk("rst.empty.dout", int'(dout), 'h800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
